// File: rtl/timing_leak_pkg.sv
// Shared definitions for the timing leak monitor and the tester wrapper:
// FSM encoding, default sizing and the per-trial result record layout.
package timing_leak_pkg;

    localparam int unsigned TLM_CNT_W   = 8;
    localparam int unsigned TLM_TIMEOUT = 64;
    localparam int unsigned TLM_TRIAL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SKEW   = 2'd2,
        ST_REPORT = 2'd3
    } tlm_state_e;

    localparam int unsigned TLM_RES_SKEW_W = TLM_CNT_W;
    localparam int unsigned TLM_RES_W      = TLM_RES_SKEW_W + 3;

    typedef struct packed {
        logic                      leak;
        logic                      timeout;
        logic                      first;
        logic [TLM_RES_SKEW_W-1:0] skew;
    } tlm_result_t;

endpackage

// File: rtl/timing_leak_monitor_if.sv
// Trial handshake between the two-copy multiplier tester (master) and the
// leak monitor (slave): shared start, both done levels, per-trial result.
interface timing_leak_monitor_if
    import timing_leak_pkg::*;
#(
    parameter int unsigned CNT_W = TLM_CNT_W
) ();

    logic             start;
    logic             done_a;
    logic             done_b;
    logic             result_valid;
    logic             result_leak;
    logic             result_timeout;
    logic [CNT_W-1:0] result_skew;
    logic             result_first;

    modport master (
        output start, done_a, done_b,
        input  result_valid, result_leak, result_timeout, result_skew, result_first
    );

    modport slave (
        input  start, done_a, done_b,
        output result_valid, result_leak, result_timeout, result_skew, result_first
    );

endinterface

// File: rtl/tlm_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment)
// and asynchronous active-low reset.
module tlm_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/timing_leak_monitor.sv
// Measures done-to-done skew between two multiplier copies per trial and flags
// skew or hangs as leaks. Optional max_skew port enabled by TLM_MAX_SKEW_EN.
module timing_leak_monitor
    import timing_leak_pkg::*;
#(
    parameter int unsigned CNT_W   = TLM_CNT_W,
    parameter int unsigned TIMEOUT = TLM_TIMEOUT,
    parameter int unsigned TRIAL_W = TLM_TRIAL_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    timing_leak_monitor_if.slave     bus,
    output logic                     leak_sticky,
    output logic [TRIAL_W-1:0]       trial_count,
    output logic [TRIAL_W-1:0]       leak_count
`ifdef TLM_MAX_SKEW_EN
    ,
    output logic [CNT_W-1:0]         max_skew
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    tlm_state_e       state_q;
    logic             first_q;
    logic             result_valid_q;
    logic             result_leak_q;
    logic             result_timeout_q;
    logic [CNT_W-1:0] result_skew_q;
    logic             result_first_q;
    logic             leak_sticky_q;
`ifdef TLM_MAX_SKEW_EN
    logic [CNT_W-1:0] max_skew_q;
`endif

    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] skew_cnt;
    logic             both_done;
    logic             one_done;
    logic             second_seen;
    logic             cyc_at_limit;
    logic             skew_at_limit;
    logic             start_accept;
    logic             cyc_clr;
    logic             cyc_inc;
    logic             skew_clr;
    logic             skew_inc;
    logic             trial_inc;
    logic             leak_inc;

    always_comb begin
        both_done     = bus.done_a & bus.done_b;
        one_done      = bus.done_a ^ bus.done_b;
        // done levels stay high, so only the copy that has not finished yet matters
        second_seen   = first_q ? bus.done_a : bus.done_b;
        cyc_at_limit  = (cyc_cnt == TIMEOUT_C);
        skew_at_limit = (skew_cnt == TIMEOUT_C);
        start_accept  = (state_q == ST_IDLE) && bus.start && !clear;
        cyc_clr       = clear | start_accept;
        cyc_inc       = (state_q == ST_RUN);
        skew_clr      = clear | start_accept;
        skew_inc      = ((state_q == ST_RUN) && one_done) ||
                        ((state_q == ST_SKEW) && !second_seen && !skew_at_limit);
        trial_inc     = (state_q == ST_REPORT);
        leak_inc      = (state_q == ST_REPORT) && result_leak_q;
    end

    tlm_sat_counter #(.W(CNT_W)) u_cyc (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cyc_clr),
        .inc_i   (cyc_inc),
        .count_o (cyc_cnt)
    );

    tlm_sat_counter #(.W(CNT_W)) u_skew (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (skew_clr),
        .inc_i   (skew_inc),
        .count_o (skew_cnt)
    );

    tlm_sat_counter #(.W(TRIAL_W)) u_trial (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clear),
        .inc_i   (trial_inc),
        .count_o (trial_count)
    );

    tlm_sat_counter #(.W(TRIAL_W)) u_leak (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clear),
        .inc_i   (leak_inc),
        .count_o (leak_count)
    );

    // Result fields are loaded on entry to REPORT so they line up with result_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            first_q          <= 1'b0;
            result_valid_q   <= 1'b0;
            result_leak_q    <= 1'b0;
            result_timeout_q <= 1'b0;
            result_skew_q    <= '0;
            result_first_q   <= 1'b0;
            leak_sticky_q    <= 1'b0;
`ifdef TLM_MAX_SKEW_EN
            max_skew_q       <= '0;
`endif
        end else if (clear) begin
            state_q          <= ST_IDLE;
            first_q          <= 1'b0;
            result_valid_q   <= 1'b0;
            leak_sticky_q    <= 1'b0;
`ifdef TLM_MAX_SKEW_EN
            max_skew_q       <= '0;
`endif
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= ST_RUN;
                        first_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (both_done) begin
                        state_q          <= ST_REPORT;
                        result_valid_q   <= 1'b1;
                        result_leak_q    <= 1'b0;
                        result_timeout_q <= 1'b0;
                        result_skew_q    <= skew_cnt;
                        result_first_q   <= 1'b0;
                    end else if (one_done) begin
                        state_q <= ST_SKEW;
                        first_q <= bus.done_b;
                    end else if (cyc_at_limit) begin
                        state_q          <= ST_REPORT;
                        result_valid_q   <= 1'b1;
                        result_leak_q    <= 1'b1;
                        result_timeout_q <= 1'b1;
                        result_skew_q    <= skew_cnt;
                        result_first_q   <= 1'b0;
                    end
                end
                ST_SKEW: begin
                    if (second_seen || skew_at_limit) begin
                        state_q          <= ST_REPORT;
                        result_valid_q   <= 1'b1;
                        result_leak_q    <= 1'b1;
                        result_timeout_q <= !second_seen;
                        result_skew_q    <= skew_cnt;
                        result_first_q   <= first_q;
                    end
                end
                ST_REPORT: begin
                    state_q       <= ST_IDLE;
                    leak_sticky_q <= leak_sticky_q | result_leak_q;
`ifdef TLM_MAX_SKEW_EN
                    if (result_skew_q > max_skew_q) begin
                        max_skew_q <= result_skew_q;
                    end
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.result_valid   = result_valid_q;
    assign bus.result_leak    = result_leak_q;
    assign bus.result_timeout = result_timeout_q;
    assign bus.result_skew    = result_skew_q;
    assign bus.result_first   = result_first_q;
    assign leak_sticky        = leak_sticky_q;
`ifdef TLM_MAX_SKEW_EN
    assign max_skew           = max_skew_q;
`endif

endmodule

// File: tb/tb_timing_leak_monitor.sv
// Directed bench for timing_leak_monitor: a default-sized instance plus a
// TRIAL_W=2 instance for saturation; covers TLM_MAX_SKEW_EN when defined.
module tb_timing_leak_monitor;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    always #5 clk = ~clk;

    timing_leak_monitor_if #(.CNT_W(8)) bus0 ();
    timing_leak_monitor_if #(.CNT_W(8)) bus1 ();

    logic [15:0] tc0, lc0;
    logic [1:0]  tc1, lc1;
    logic        ls0, ls1;
`ifdef TLM_MAX_SKEW_EN
    logic [7:0]  ms0, ms1;
`endif

    timing_leak_monitor #(.CNT_W(8), .TIMEOUT(64), .TRIAL_W(16)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .bus         (bus0),
        .leak_sticky (ls0),
        .trial_count (tc0),
        .leak_count  (lc0)
`ifdef TLM_MAX_SKEW_EN
        ,
        .max_skew    (ms0)
`endif
    );

    timing_leak_monitor #(.CNT_W(8), .TIMEOUT(64), .TRIAL_W(2)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .bus         (bus1),
        .leak_sticky (ls1),
        .trial_count (tc1),
        .leak_count  (lc1)
`ifdef TLM_MAX_SKEW_EN
        ,
        .max_skew    (ms1)
`endif
    );

    // sel steers stimulus to one instance and picks which one is observed
    logic sel;
    logic start_r, da_r, db_r;

    assign bus0.start  = !sel & start_r;
    assign bus0.done_a = !sel & da_r;
    assign bus0.done_b = !sel & db_r;
    assign bus1.start  = sel & start_r;
    assign bus1.done_a = sel & da_r;
    assign bus1.done_b = sel & db_r;

    logic        vld, leak, tout, first, ls;
    logic [7:0]  skew;
    logic [15:0] tc, lc;

    assign vld   = sel ? bus1.result_valid   : bus0.result_valid;
    assign leak  = sel ? bus1.result_leak    : bus0.result_leak;
    assign tout  = sel ? bus1.result_timeout : bus0.result_timeout;
    assign first = sel ? bus1.result_first   : bus0.result_first;
    assign skew  = sel ? bus1.result_skew    : bus0.result_skew;
    assign ls    = sel ? ls1 : ls0;
    assign tc    = sel ? {14'd0, tc1} : tc0;
    assign lc    = sel ? {14'd0, lc1} : lc0;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // da/db: cycle (1 = first edge after start) at which each done rises, 0 = never.
    // restart: cycle at which start is pulsed again mid-trial, 0 = never.
    task automatic run_trial(input int da, input int db, input int restart, output int lat);
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            da_r    = (da > 0) && (c >= da);
            db_r    = (db > 0) && (c >= db);
            start_r = (c == restart);
            tick();
            if (vld) begin
                lat = c;
                break;
            end
        end
        start_r = 1'b0;
    endtask

    task automatic finish_trial();
        tick();
        da_r = 1'b0;
        db_r = 1'b0;
    endtask

    initial begin
        int lat;
        int pulses;
        rst     = 1'b0;
        clear   = 1'b0;
        start_r = 1'b0;
        da_r    = 1'b0;
        db_r    = 1'b0;
        sel     = 1'b0;
        tick(3);
        check("rst_valid", vld, 0);
        check("rst_trial", tc, 0);
        check("rst_leakc", lc, 0);
        check("rst_sticky", ls, 0);
        check("rst_skew", skew, 0);
        rst = 1'b1;
        tick();

        // tie at cycle 5
        run_trial(5, 5, 0, lat);
        check("t1_lat", lat, 5);
        check("t1_leak", leak, 0);
        check("t1_tout", tout, 0);
        check("t1_skew", skew, 0);
        finish_trial();
        check("t1_pulse", vld, 0);
        check("t1_trial", tc, 1);
        check("t1_sticky", ls, 0);

        // a@5, b@8
        run_trial(5, 8, 0, lat);
        check("t2_lat", lat, 8);
        check("t2_leak", leak, 1);
        check("t2_tout", tout, 0);
        check("t2_skew", skew, 3);
        check("t2_first", first, 0);
        finish_trial();
        check("t2_trial", tc, 2);
        check("t2_leakc", lc, 1);
        check("t2_sticky", ls, 1);

        // hang in RUN
        run_trial(0, 0, 0, lat);
        check("t3_lat", lat, 65);
        check("t3_tout", tout, 1);
        check("t3_leak", leak, 1);
        check("t3_skew", skew, 0);
        finish_trial();
        check("t3_leakc", lc, 2);

        // b@4, a never: SKEW timeout
        run_trial(0, 4, 0, lat);
        check("t4_lat", lat, 68);
        check("t4_tout", tout, 1);
        check("t4_skew", skew, 64);
        check("t4_first", first, 1);
        finish_trial();
        check("t4_trial", tc, 4);
        check("t4_leakc", lc, 3);
`ifdef TLM_MAX_SKEW_EN
        check("t4_max", ms0, 64);
`endif

        // async reset while in SKEW
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        da_r = 1'b1;
        tick(4);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_trial", tc, 0);
        check("t5_rst_leakc", lc, 0);
        check("t5_rst_sticky", ls, 0);
        check("t5_rst_skew", skew, 0);
        check("t5_rst_first", first, 0);
        check("t5_rst_tout", tout, 0);
`ifdef TLM_MAX_SKEW_EN
        check("t5_rst_max", ms0, 0);
`endif
        tick();
        rst = 1'b1;
        db_r = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (vld) pulses++;
        end
        check("t5_no_result", pulses, 0);
        da_r = 1'b0;
        db_r = 1'b0;
        tick();

        // three leaky trials, then clear with a colliding start
        run_trial(2, 4, 0, lat);
        check("t5_a_skew", skew, 2);
        finish_trial();
        run_trial(3, 4, 0, lat);
        check("t5_b_skew", skew, 1);
        finish_trial();
        run_trial(7, 2, 0, lat);
        check("t5_c_skew", skew, 5);
        check("t5_c_first", first, 1);
        finish_trial();
        check("t5_leakc", lc, 3);
        check("t5_sticky", ls, 1);
`ifdef TLM_MAX_SKEW_EN
        check("t5_max", ms0, 5);
`endif
        clear   = 1'b1;
        start_r = 1'b1;
        tick();
        clear   = 1'b0;
        start_r = 1'b0;
        check("t5_clr_leakc", lc, 0);
        check("t5_clr_trial", tc, 0);
        check("t5_clr_sticky", ls, 0);
`ifdef TLM_MAX_SKEW_EN
        check("t5_clr_max", ms0, 0);
`endif
        da_r = 1'b1;
        db_r = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (vld) pulses++;
        end
        check("t5_clr_start_dropped", pulses, 0);
        da_r = 1'b0;
        db_r = 1'b0;

        // TRIAL_W=2 instance: saturation and ignored restart
        sel = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) begin
            run_trial(2, 2, 0, lat);
            check("t6_lat", lat, 2);
            finish_trial();
            check("t6_trial", tc, (i < 3) ? i : 3);
        end
        run_trial(0, 0, 3, lat);
        check("t6_restart_lat", lat, 65);
        finish_trial();
        check("t6_trial_sat", tc, 3);
        check("t6_leakc", lc, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
